// File: rtl/execute_stage_pkg.sv
// Shared execute-stage types: ALU op codes, forward selects, pipeline register layouts.
package execute_stage_pkg;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  // ALU op codes, shared with the ALU control decoder
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0100,
    ALU_SRA = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SRL = 4'b1000,
    ALU_LUI = 4'b1001,
    ALU_NOR = 4'b1100,
    ALU_XOR = 4'b1101
  } alu_op_e;

  // Operand forward selects; 2'b11 falls back to the register value
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [3:0]      alu_instr;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] sign_imm;
    logic [RW-1:0]   shamt;
    logic [RW-1:0]   rs;
    logic [RW-1:0]   rt;
    logic [RW-1:0]   rd;
    logic            alusrc;
    logic            regdst;
    logic            regwrite;
    logic            memwrite;
    logic            memtoreg;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] write_data;
    logic [RW-1:0]   write_reg;
    logic            regwrite;
    logic            memwrite;
    logic            memtoreg;
    logic            illegal;
  } ex_mem_t;

  // Shift ops take their operand from the forwarded rt value, never the immediate
  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/execute_stage_alu_core.sv
// Combinational ALU; unknown op codes give 0 and flag illegal.
module alu_core
  import execute_stage_pkg::*;
(
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [RW-1:0]   shamt,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  // Decode op and compute result; arithmetic wraps, no overflow trap
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_NOR: result = ~(src_a | src_b);
      ALU_XOR: result = src_a ^ src_b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLL: result = src_b << shamt;
      ALU_SRL: result = src_b >> shamt;
      ALU_SRA: result = $unsigned($signed(src_b) >>> shamt);
      ALU_LUI: result = {src_b[15:0], 16'h0000};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, EX/MEM register.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      ALU_Instruction_D,
  input  logic [XLEN-1:0] RD1_D,
  input  logic [XLEN-1:0] RD2_D,
  input  logic [XLEN-1:0] SignImm_D,
  input  logic [RW-1:0]   Shamt_D,
  input  logic [RW-1:0]   Rs_D,
  input  logic [RW-1:0]   Rt_D,
  input  logic [RW-1:0]   Rd_D,
  input  logic            ALUSrc_D,
  input  logic            RegDst_D,
  input  logic            RegWrite_D,
  input  logic            MemWrite_D,
  input  logic            MemtoReg_D,
  input  logic            Stall_E,
  input  logic            Flush_E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] Result_W,
  output logic [RW-1:0]   Rs_E,
  output logic [RW-1:0]   Rt_E,
  output logic [RW-1:0]   WriteReg_E,
  output logic            RegWrite_E,
  output logic            MemtoReg_E,
  output logic [XLEN-1:0] ALUOut_M,
  output logic [XLEN-1:0] WriteData_M,
  output logic [RW-1:0]   WriteReg_M,
  output logic            RegWrite_M,
  output logic            MemWrite_M,
  output logic            MemtoReg_M,
  output logic            Illegal_M
);

  id_ex_t          id_ex_d, id_ex_q;
  ex_mem_t         ex_mem_d, ex_mem_q;
  logic [XLEN-1:0] src_a, src_b, alu_b, write_data_e, alu_res;
  logic [RW-1:0]   write_reg_e;
  logic            alu_illegal;

  // Pack decode inputs; a flush turns the instruction into a no-write bubble
  always_comb begin
    id_ex_d           = '0;
    id_ex_d.alu_instr = ALU_Instruction_D;
    id_ex_d.rd1       = RD1_D;
    id_ex_d.rd2       = RD2_D;
    id_ex_d.sign_imm  = SignImm_D;
    id_ex_d.shamt     = Shamt_D;
    id_ex_d.rs        = Rs_D;
    id_ex_d.rt        = Rt_D;
    id_ex_d.rd        = Rd_D;
    id_ex_d.alusrc    = ALUSrc_D;
    id_ex_d.regdst    = RegDst_D;
    id_ex_d.regwrite  = RegWrite_D & ~Flush_E;
    id_ex_d.memwrite  = MemWrite_D & ~Flush_E;
    id_ex_d.memtoreg  = MemtoReg_D & ~Flush_E;
  end

  // ID/EX register: stall holds (and beats flush), reset clears everything
  always_ff @(posedge clk) begin
    if (!rst_n)        id_ex_q <= '0;
    else if (!Stall_E) id_ex_q <= id_ex_d;
  end

  // Operand forwarding; the MEM source is the EX/MEM register, so no comb loop
  always_comb begin
    case (ForwardA_E)
      FWD_WB:  src_a = Result_W;
      FWD_MEM: src_a = ex_mem_q.alu_out;
      default: src_a = id_ex_q.rd1;
    endcase
    case (ForwardB_E)
      FWD_WB:  write_data_e = Result_W;
      FWD_MEM: write_data_e = ex_mem_q.alu_out;
      default: write_data_e = id_ex_q.rd2;
    endcase
  end

  assign src_b       = id_ex_q.alusrc ? id_ex_q.sign_imm : write_data_e;
  // Shifts always act on the rt value even if ALUSrc was set
  assign alu_b       = is_shift(id_ex_q.alu_instr) ? write_data_e : src_b;
  assign write_reg_e = id_ex_q.regdst ? id_ex_q.rd : id_ex_q.rt;

  alu_core u_alu (
    .src_a   (src_a),
    .src_b   (alu_b),
    .shamt   (id_ex_q.shamt),
    .op      (id_ex_q.alu_instr),
    .result  (alu_res),
    .illegal (alu_illegal)
  );

  // Build EX/MEM payload; an illegal op may not write anything
  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.alu_out    = alu_res;
    ex_mem_d.write_data = write_data_e;
    ex_mem_d.write_reg  = write_reg_e;
    ex_mem_d.regwrite   = id_ex_q.regwrite & ~alu_illegal;
    ex_mem_d.memwrite   = id_ex_q.memwrite & ~alu_illegal;
    ex_mem_d.memtoreg   = id_ex_q.memtoreg;
    ex_mem_d.illegal    = alu_illegal;
  end

  // EX/MEM register: a stall inserts an all-zero bubble behind the held instruction
  always_ff @(posedge clk) begin
    if (!rst_n || Stall_E) ex_mem_q <= '0;
    else                   ex_mem_q <= ex_mem_d;
  end

  assign Rs_E        = id_ex_q.rs;
  assign Rt_E        = id_ex_q.rt;
  assign WriteReg_E  = write_reg_e;
  assign RegWrite_E  = id_ex_q.regwrite;
  assign MemtoReg_E  = id_ex_q.memtoreg;
  assign ALUOut_M    = ex_mem_q.alu_out;
  assign WriteData_M = ex_mem_q.write_data;
  assign WriteReg_M  = ex_mem_q.write_reg;
  assign RegWrite_M  = ex_mem_q.regwrite;
  assign MemWrite_M  = ex_mem_q.memwrite;
  assign MemtoReg_M  = ex_mem_q.memtoreg;
  assign Illegal_M   = ex_mem_q.illegal;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with hand-computed expectations.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ALU_Instruction_D;
  logic [31:0] RD1_D, RD2_D, SignImm_D, Result_W;
  logic [4:0]  Shamt_D, Rs_D, Rt_D, Rd_D;
  logic        ALUSrc_D, RegDst_D, RegWrite_D, MemWrite_D, MemtoReg_D;
  logic        Stall_E, Flush_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [4:0]  Rs_E, Rt_E, WriteReg_E, WriteReg_M;
  logic        RegWrite_E, MemtoReg_E;
  logic [31:0] ALUOut_M, WriteData_M;
  logic        RegWrite_M, MemWrite_M, MemtoReg_M, Illegal_M;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ALU_Instruction_D(ALU_Instruction_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
    .SignImm_D(SignImm_D), .Shamt_D(Shamt_D), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
    .ALUSrc_D(ALUSrc_D), .RegDst_D(RegDst_D), .RegWrite_D(RegWrite_D),
    .MemWrite_D(MemWrite_D), .MemtoReg_D(MemtoReg_D),
    .Stall_E(Stall_E), .Flush_E(Flush_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .Result_W(Result_W),
    .Rs_E(Rs_E), .Rt_E(Rt_E), .WriteReg_E(WriteReg_E),
    .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
    .ALUOut_M(ALUOut_M), .WriteData_M(WriteData_M), .WriteReg_M(WriteReg_M),
    .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .MemtoReg_M(MemtoReg_M),
    .Illegal_M(Illegal_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop_d();
    ALU_Instruction_D = 4'b0000;
    RD1_D = '0; RD2_D = '0; SignImm_D = '0;
    Shamt_D = '0; Rs_D = '0; Rt_D = '0; Rd_D = '0;
    ALUSrc_D = 0; RegDst_D = 0; RegWrite_D = 0; MemWrite_D = 0; MemtoReg_D = 0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] sh, input logic src);
    nop_d();
    ALU_Instruction_D = op; RD1_D = a; RD2_D = b; SignImm_D = imm;
    Shamt_D = sh; ALUSrc_D = src; RegWrite_D = 1;
  endtask

  // One instruction through both stages, then check the ALU result
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [4:0] sh,
                        input logic src, input logic [31:0] exp);
    set_op(op, a, b, imm, sh, src);
    tick();
    nop_d();
    tick();
    chk(tag, ALUOut_M, exp);
  endtask

  initial begin
    nop_d();
    Stall_E = 0; Flush_E = 0; ForwardA_E = 0; ForwardB_E = 0; Result_W = '0;
    rst_n = 0;
    tick(); tick();
    chk("rst_aluout", ALUOut_M, 0);
    chk("rst_regwr_m", {31'b0, RegWrite_M}, 0);
    chk("rst_illegal", {31'b0, Illegal_M}, 0);
    chk("rst_wreg_e", {27'b0, WriteReg_E}, 0);
    rst_n = 1;

    // SUB 7-5 with RegDst to rd=9
    set_op(4'b0110, 32'd7, 32'd5, '0, '0, 0);
    Rs_D = 5'd1; Rt_D = 5'd2; Rd_D = 5'd9; RegDst_D = 1;
    tick();
    chk("sub_rs_e", {27'b0, Rs_E}, 1);
    chk("sub_rt_e", {27'b0, Rt_E}, 2);
    chk("sub_wreg_e", {27'b0, WriteReg_E}, 9);
    chk("sub_regwr_e", {31'b0, RegWrite_E}, 1);
    nop_d();
    tick();
    chk("sub_aluout", ALUOut_M, 2);
    chk("sub_regwr_m", {31'b0, RegWrite_M}, 1);
    chk("sub_wreg_m", {27'b0, WriteReg_M}, 9);

    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, '0, '0, 0, 32'h0);
    run_op("sub_wrap", 4'b0110, 32'd0, 32'd1, '0, '0, 0, 32'hFFFF_FFFF);
    run_op("slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'd1, '0, '0, 0, 32'd1);
    run_op("slt_pos",  4'b0111, 32'd1, 32'hFFFF_FFFF, '0, '0, 0, 32'd0);
    run_op("and",      4'b0000, 32'hF0F0_1234, 32'hFF00_FF00, '0, '0, 0, 32'hF000_1200);
    run_op("or",       4'b0001, 32'hF0F0_0000, 32'h0000_000F, '0, '0, 0, 32'hF0F0_000F);
    run_op("nor",      4'b1100, 32'hF0F0_0000, 32'h0000_000F, '0, '0, 0, 32'h0F0F_FFF0);
    run_op("xor",      4'b1101, 32'hFFFF_0000, 32'h0F0F_0F0F, '0, '0, 0, 32'hF0F0_0F0F);
    run_op("sll",      4'b0100, 32'h0, 32'h0000_0081, '0, 5'd4, 0, 32'h0000_0810);
    run_op("srl",      4'b1000, 32'h0, 32'h8000_0000, '0, 5'd4, 0, 32'h0800_0000);
    run_op("sra",      4'b0101, 32'h0, 32'h8000_0000, '0, 5'd4, 0, 32'hF800_0000);
    run_op("lui",      4'b1001, 32'h0, 32'h0, 32'h0000_1234, '0, 1, 32'h1234_0000);
    run_op("add_imm",  4'b0010, 32'd100, 32'd7, 32'hFFFF_FFFF, '0, 1, 32'd99);

    // Forwarding: previous result 0x10 in EX/MEM, Result_W=3
    set_op(4'b0010, 32'h10, 32'h0, '0, '0, 0);
    tick();
    set_op(4'b0010, 32'hDEAD, 32'hBEEF, '0, '0, 0);
    tick();
    chk("fwd_prev", ALUOut_M, 32'h10);
    nop_d();
    ForwardA_E = 2'b10; ForwardB_E = 2'b01; Result_W = 32'd3;
    tick();
    chk("fwd_aluout", ALUOut_M, 32'h13);
    chk("fwd_wdata", WriteData_M, 32'd3);
    ForwardA_E = 2'b11; ForwardB_E = 2'b00; Result_W = 32'd0;
    set_op(4'b0010, 32'd20, 32'd22, '0, '0, 0);
    tick();
    nop_d();
    tick();
    chk("fwd_11_reg", ALUOut_M, 32'd42);
    ForwardA_E = 2'b00;

    // Stall two cycles (second also flushed: stall wins), then release
    set_op(4'b0010, 32'd1, 32'd2, '0, '0, 0);
    tick();
    nop_d();
    Stall_E = 1;
    tick();
    chk("stall_bub1", {31'b0, RegWrite_M}, 0);
    Flush_E = 1;
    tick();
    chk("stall_bub2", {31'b0, RegWrite_M}, 0);
    chk("stall_bub2_out", ALUOut_M, 0);
    Stall_E = 0; Flush_E = 0;
    tick();
    chk("stall_emerge", ALUOut_M, 32'd3);
    chk("stall_emerge_wr", {31'b0, RegWrite_M}, 1);
    tick();
    chk("stall_once", {31'b0, RegWrite_M}, 0);

    // Flush clears control into ID/EX
    set_op(4'b0010, 32'd4, 32'd4, '0, '0, 0);
    MemWrite_D = 1; MemtoReg_D = 1; Flush_E = 1;
    tick();
    chk("flush_regwr_e", {31'b0, RegWrite_E}, 0);
    chk("flush_m2r_e", {31'b0, MemtoReg_E}, 0);
    Flush_E = 0; nop_d();
    tick();
    chk("flush_regwr_m", {31'b0, RegWrite_M}, 0);
    chk("flush_memwr_m", {31'b0, MemWrite_M}, 0);

    // Illegal ops
    set_op(4'b1111, 32'd5, 32'd6, '0, '0, 0);
    MemWrite_D = 1;
    tick();
    nop_d();
    tick();
    chk("ill_flag", {31'b0, Illegal_M}, 1);
    chk("ill_out", ALUOut_M, 0);
    chk("ill_regwr", {31'b0, RegWrite_M}, 0);
    chk("ill_memwr", {31'b0, MemWrite_M}, 0);
    set_op(4'b0011, 32'd5, 32'd6, '0, '0, 0);
    tick();
    nop_d();
    tick();
    chk("ill_0011", {31'b0, Illegal_M}, 1);
    tick();
    chk("ill_clear", {31'b0, Illegal_M}, 0);

    // Mid-stream reset with stall/flush asserted
    set_op(4'b0010, 32'd8, 32'd9, '0, '0, 0);
    Rs_D = 5'd3; Rt_D = 5'd4; MemWrite_D = 1; MemtoReg_D = 1;
    tick();
    set_op(4'b0010, 32'd1, 32'd1, '0, '0, 0);
    Rs_D = 5'd5; Rt_D = 5'd6; ForwardB_E = 2'b01; Result_W = 32'h55;
    rst_n = 0; Stall_E = 1; Flush_E = 1;
    tick();
    ForwardB_E = 2'b00; Result_W = '0;
    chk("mrst_aluout", ALUOut_M, 0);
    chk("mrst_wdata", WriteData_M, 0);
    chk("mrst_regwr_m", {31'b0, RegWrite_M}, 0);
    chk("mrst_memwr_m", {31'b0, MemWrite_M}, 0);
    chk("mrst_m2r_m", {31'b0, MemtoReg_M}, 0);
    chk("mrst_regwr_e", {31'b0, RegWrite_E}, 0);
    chk("mrst_rs_e", {27'b0, Rs_E}, 0);
    chk("mrst_rt_e", {27'b0, Rt_E}, 0);
    rst_n = 1; Stall_E = 0; Flush_E = 0; nop_d();
    tick();
    chk("mrst_discard", {31'b0, RegWrite_M}, 0);
    chk("mrst_discard_out", ALUOut_M, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
